// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: multi-cycle diff = a - b - bin, one 4-bit slice
// per clock (LS nibble first) with a ripple borrow carried between slices.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b, bin); ready only in IDLE
//   out_valid/out_ready   result handshake (diff, bout, zero, ovf); valid in DONE
//   diff                  (a - b - bin) mod 2^WIDTH
//   bout, zero, ovf       borrow out, diff==0, signed overflow
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [WIDTH-1:0] diff_q;
  logic            bout_q;
  logic            zero_q;
  logic            ovf_q;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [4:0]      sum_d;
  logic [WIDTH-1:0] diff_d;
  logic            last;

  // Subtraction as a + ~b + carry, where carry = ~borrow.
  always_comb begin
    a_nib  = a_q[4*int'(idx_q) +: 4];
    b_nib  = b_q[4*int'(idx_q) +: 4];
    sum_d  = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0, carry_q};
    diff_d = diff_q;
    diff_d[4*int'(idx_q) +: 4] = sum_d[3:0];
    last   = (idx_q == IW'(NIBBLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ~bin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          diff_q  <= diff_d;
          carry_q <= sum_d[4];
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            bout_q  <= ~sum_d[4];
            zero_q  <= (diff_d == '0);
            ovf_q   <= (a_q[MSB] != b_q[MSB]) &&
                       (diff_d[MSB] != a_q[MSB]);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed vectors for the nibble-serial
// subtractor, WIDTH=16, hand-computed expected results.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero),
    .ovf      (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, check latency and results; leaves the DUT in DONE.
  task automatic run_op(input string tag, input logic [15:0] av,
                        input logic [15:0] bv, input logic bi,
                        input logic [15:0] ed, input logic eb,
                        input logic ez, input logic eo);
    int cnt;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    bin = bi;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    bin = ~bi;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (out_valid) break;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'd4);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_ov"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic seen_ov;
    logic [15:0] hold;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", {29'd0, bout, zero, ovf}, 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);

    run_op("s1", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    release_op("s1");
    run_op("s2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    release_op("s2");
    run_op("s3", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    release_op("s3");
    run_op("s4", 16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    release_op("s4");
    run_op("eq", 16'h00AA, 16'h00AA, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    release_op("eq");
    run_op("mix", 16'h7000, 16'h9000, 1'b0, 16'hE000, 1'b1, 1'b0, 1'b1);
    release_op("mix");

    // Backpressure: hold DONE while the input side toggles.
    run_op("bp", 16'h0F0F, 16'h0101, 1'b0, 16'h0E0E, 1'b0, 1'b0, 1'b0);
    hold = diff;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'h1111 * 16'(i + 1);
      b = 16'h0F0F ^ 16'(i);
      bin = i[0];
      @(posedge clk);
      @(negedge clk);
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_diff", 32'(diff), 32'(hold));
      chk("bp_flags", {29'd0, bout, zero, ovf}, 32'd0);
    end
    in_valid = 1'b0;
    release_op("bp");
    chk("bp_keep", 32'(diff), 32'h0E0E);

    // Reset after two RUN cycles aborts the op.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h0000;
    b = 16'h0001;
    bin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ar_diff", 32'(diff), 32'd0);
    chk("ar_flags", {29'd0, bout, zero, ovf}, 32'd0);
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_rdy", 32'(in_ready), 32'd1);
    seen_ov = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_ov = 1'b1;
    end
    chk("ar_never_ov", 32'(seen_ov), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
